// File: rtl/bus_write_port.sv
// CPU-side write port for the text display: synchronises the asynchronous 6502 bus
// into the pixel clock domain and drives the character RAM write port.
module bus_write_port #(
  parameter int COLS        = 100,
  parameter int ROWS        = 75,
  parameter int ADDR_W      = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              ext_clock,
  input  logic              chip_enable,
  input  logic              read_write,
  input  logic [1:0]        address,
  input  logic [7:0]        data_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  output logic [2:0]        fg_color_out,
  output logic              busy_out
);

  typedef struct packed {
    logic       phi2;
    logic       ce;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [7:0]        BLANK     = 8'h20;

  bus_t [SYNC_STAGES-1:0] sync_q;
  bus_t                   bus_s;
  bus_t                   snap_q;
  logic                   phi2_prev_q;
  logic                   bus_wr;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [2:0]          fg_q, fg_d;
  logic                busy_q, busy_d;

  assign bus_s = sync_q[SYNC_STAGES-1];

  // A bus cycle ends on the synced phi2 falling edge; the snapshot taken while
  // phi2 was high holds the settled address/data. Busy blocks everything.
  assign bus_wr = phi2_prev_q && !bus_s.phi2 && snap_q.ce && !snap_q.rw && (state_q == IDLE);

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of statement order.
    if (reset_in) begin
      sync_q      <= '0;
      snap_q      <= '0;
      phi2_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {ext_clock, chip_enable, read_write, address, data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      phi2_prev_q <= bus_s.phi2;
      if (bus_s.phi2) snap_q <= bus_s;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      cursor_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fg_q      <= 3'b111;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fg_q      <= fg_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave
    // one unassigned and infer a latch.
    state_d   = state_q;
    cursor_d  = cursor_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    fg_d      = fg_q;
    busy_d    = busy_q;

    if (state_q == CLEAR) begin
      // wr_addr_q doubles as the clear counter; the first strobe was issued on entry.
      if (wr_addr_q == LAST_CELL) begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        cursor_d = '0;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        wr_data_d = BLANK;
      end
    end else if (bus_wr) begin
      case (snap_q.addr)
        2'd0: cursor_d[7:0] = snap_q.data;
        2'd1: cursor_d[ADDR_W-1:8] = snap_q.data[ADDR_W-9:0];
        2'd2: begin
          if (cursor_q > LAST_CELL) begin
            cursor_d = '0;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_q;
            wr_data_d = snap_q.data;
            cursor_d  = (cursor_q == LAST_CELL) ? '0 : cursor_q + ADDR_W'(1);
          end
        end
        default: begin
          fg_d = snap_q.data[6:4];
          if (snap_q.data[0]) begin
            state_d   = CLEAR;
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = BLANK;
          end
        end
      endcase
    end
  end

  assign wr_en_out    = wr_en_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;
  assign fg_color_out = fg_q;
  assign busy_out     = busy_q;

endmodule
